dmem_responder: RTL and testbench
=================================

DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 SHALL have parameter ADDR_W, default 10, meaning the SRAM word-address width (4*2^ADDR_W bytes addressable).
REQ-002 SHALL have ports: clk input 1, the single clock; all logic is rising-edge.
REQ-003 rst input 1, asynchronous, active-high reset.
REQ-004 R_en input 1, load request from the core.
REQ-005 W_en input 1, store request from the core.
REQ-006 addr input 32, byte address.
REQ-007 RW_type input 3, access type: 000 B, 001 H, 010 W, 100 BU, 101 HU.
REQ-008 din input 32, store data, right-aligned.
REQ-009 dout output 32, load data, extended to 32 bits.
REQ-010 ready output 1, one-cycle completion pulse.
REQ-011 mem_ce output 1, SRAM chip enable.
REQ-012 mem_we output 1, SRAM write enable.
REQ-013 mem_be output 4, SRAM byte enables.
REQ-014 mem_addr output ADDR_W, SRAM word address.
REQ-015 mem_wdata output 32, lane-shifted write data.
REQ-016 mem_rdata input 32, SRAM read data, valid one cycle after a read with mem_ce=1.

Function
REQ-017 SHALL implement FSM IDLE -> ACCESS -> (WAIT for loads) -> DONE -> IDLE.
REQ-018 In IDLE, R_en or W_en high SHALL capture addr/RW_type/din into registers; W_en SHALL win when both are high.
REQ-019 In ACCESS, the block SHALL drive registered mem_ce=1, with mem_addr = addr[ADDR_W+1:2] and upper address bits ignored (wrap). For stores it SHALL also drive mem_we=1.
REQ-020 Store byte enables SHALL be: B 0001<<addr[1:0]; H 0011<<addr[1]*2; W/other 1111. mem_wdata SHALL be din replicated per lane.
REQ-021 In WAIT, mem_rdata SHALL be lane-selected by addr[1:0]; B/H SHALL be sign-extended and BU/HU zero-extended; W, 011 and 11x SHALL return the full word. The result SHALL be registered into dout.
REQ-022 In DONE, ready=1 for exactly one cycle. dout SHALL hold its value until the next load completes; stores SHALL leave dout unchanged.
REQ-023 Latency, request sampled in cycle 0: store ready in cycle 2; load ready in cycle 3. Throughput is one request per 3 or 4 cycles.
REQ-024 The core SHALL change or drop its request in the cycle after ready; a request still held in IDLE SHALL be executed again.
REQ-025 Request deassertion after capture SHALL NOT abort the operation.
REQ-026 Outside ACCESS, mem_ce, mem_we and mem_be SHALL be 0.

Reset
REQ-027 rst SHALL force IDLE with dout=0, ready=0, mem_ce=0, mem_we=0, mem_be=0, mem_addr=0 and mem_wdata=0.
REQ-028 rst during any state SHALL abort the operation; no SRAM write SHALL occur after rst asserts and no ready pulse is issued.

Configuration
REQ-029 Macro DMEM_MISALIGN_CHK_EN defined: adds output err (1 bit, reset 0). A halfword access with addr[0]=1 or a word access with addr[1:0]!=0 SHALL go IDLE->DONE with no SRAM access, ready=1 and err=1 in the same cycle, and dout forced to 0.
REQ-030 Macro undefined: no err port; misaligned addresses SHALL be silently aligned down to the access size.

Structure
REQ-031 Package dmem_pkg SHALL hold the RW_type encodings, the FSM state enum, and the lane/byte-enable width constants.
REQ-032 Sub-module load_extend (combinational lane select plus sign/zero extension) SHALL be instantiated once.

Verification
REQ-033 SW at addr 0x10, din 0xDEADBEEF: be=1111, mem_addr=4, ready in cycle 2; then LW at 0x10 returns 0xDEADBEEF with ready in cycle 3.
REQ-034 SB 0x000000A5 at 0x13: be=1000, wdata lane3=A5. Then LB at 0x13 returns 0xFFFFFFA5 and LBU returns 0x000000A5.
REQ-035 SH 0x8001 at 0x22, then LH at 0x22 returns 0xFFFF8001 and LHU returns 0x00008001.
REQ-036 R_en and W_en both high: a store is performed. With rst pulsed in ACCESS of a store: no mem_we, and outputs return to the reset values of REQ-027.
REQ-037 LW at 0x11: with DMEM_MISALIGN_CHK_EN, err=1, dout=0, mem_ce never high. Without it, the access reads word 0x10.
REQ-038 Address 0x00001010 with ADDR_W=10 wraps to mem_addr=4.

Source files
------------

// File: rtl/dmem_pkg.sv
// dmem_pkg -- shared definitions for the data-memory responder.
//   * RW_type access encodings (B, H, W, BU, HU)
//   * FSM state enum
//   * lane / byte-enable width constants
//   * helpers for lane alignment, byte enables and store-data replication
package dmem_pkg;

  localparam int DATA_W = 32;
  localparam int LANE_W = 8;
  localparam int LANES  = DATA_W / LANE_W;
  localparam int BE_W   = LANES;

  localparam logic [2:0] RW_B  = 3'b000;
  localparam logic [2:0] RW_H  = 3'b001;
  localparam logic [2:0] RW_W  = 3'b010;
  localparam logic [2:0] RW_BU = 3'b100;
  localparam logic [2:0] RW_HU = 3'b101;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACCESS,
    S_WAIT,
    S_DONE
  } state_e;

  function automatic logic is_byte(input logic [2:0] t);
    return (t == RW_B) || (t == RW_BU);
  endfunction

  function automatic logic is_half(input logic [2:0] t);
    return (t == RW_H) || (t == RW_HU);
  endfunction

  // Byte offset after rounding down to the natural size of the access;
  // every encoding that is not a byte or halfword behaves as a word.
  function automatic logic [1:0] align_off(input logic [2:0] t, input logic [1:0] off);
    if (is_byte(t))      return off;
    else if (is_half(t)) return {off[1], 1'b0};
    else                 return 2'b00;
  endfunction

  function automatic logic misaligned(input logic [2:0] t, input logic [1:0] off);
    return align_off(t, off) != off;
  endfunction

  function automatic logic [BE_W-1:0] store_be(input logic [2:0] t, input logic [1:0] off);
    if (t == RW_B)      return 4'b0001 << off;
    else if (t == RW_H) return 4'b0011 << {off[1], 1'b0};
    else                return 4'b1111;
  endfunction

  // Right-aligned store data copied into every lane so the byte enables
  // alone decide which lane lands in the SRAM.
  function automatic logic [DATA_W-1:0] store_wdata(input logic [2:0] t, input logic [DATA_W-1:0] d);
    if (t == RW_B)      return {LANES{d[7:0]}};
    else if (t == RW_H) return {2{d[15:0]}};
    else                return d;
  endfunction

endpackage

// File: rtl/dmem_if.sv
// dmem_if -- core request/response and SRAM port bundle.
//   Core side : R_en, W_en, addr, RW_type, din -> dout, ready
//   SRAM side : mem_ce, mem_we, mem_be, mem_addr, mem_wdata -> mem_rdata
//   modport slave  : the responder
//   modport master : the core plus SRAM environment around it
interface dmem_if #(
  parameter int ADDR_W = 10
);
  import dmem_pkg::*;

  logic              R_en;
  logic              W_en;
  logic [31:0]       addr;
  logic [2:0]        RW_type;
  logic [DATA_W-1:0] din;
  logic [DATA_W-1:0] dout;
  logic              ready;
  logic              mem_ce;
  logic              mem_we;
  logic [BE_W-1:0]   mem_be;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  R_en, W_en, addr, RW_type, din, mem_rdata,
    output dout, ready, mem_ce, mem_we, mem_be, mem_addr, mem_wdata
  );

  modport master (
    output R_en, W_en, addr, RW_type, din, mem_rdata,
    input  dout, ready, mem_ce, mem_we, mem_be, mem_addr, mem_wdata
  );

endinterface

// File: rtl/load_extend.sv
// load_extend -- selects the addressed lane of an SRAM read word and
// sign- or zero-extends it to 32 bits.
//   i_rdata   : raw SRAM word
//   i_off     : byte offset of the access (addr[1:0])
//   i_rw_type : access type
//   o_data    : extended load result
module load_extend
  import dmem_pkg::*;
(
  input  logic [DATA_W-1:0] i_rdata,
  input  logic [1:0]        i_off,
  input  logic [2:0]        i_rw_type,
  output logic [DATA_W-1:0] o_data
);

  logic [1:0]        w_off;
  logic [DATA_W-1:0] w_shifted;

  always_comb begin
    // NOTE: every output of a combinational block gets a value before the
    // case, so no path leaves it unassigned and no latch is inferred.
    w_off     = align_off(i_rw_type, i_off);
    w_shifted = i_rdata >> {w_off, 3'b000};
    o_data    = i_rdata;
    case (i_rw_type)
      RW_B:    o_data = {{24{w_shifted[7]}}, w_shifted[7:0]};
      RW_BU:   o_data = {24'h0, w_shifted[7:0]};
      RW_H:    o_data = {{16{w_shifted[15]}}, w_shifted[15:0]};
      RW_HU:   o_data = {16'h0, w_shifted[15:0]};
      default: o_data = i_rdata;
    endcase
  end

endmodule

// File: rtl/dmem_responder.sv
// dmem_responder -- turns core load/store requests into single-cycle SRAM
// accesses. Store: ready two cycles after the request is sampled; load:
// three cycles (the SRAM returns data one cycle after the read).
//   clk, rst : clock and asynchronous active-high reset
//   bus      : dmem_if.slave (core request/response plus SRAM port)
//   err      : misalignment flag, present only with DMEM_MISALIGN_CHK_EN
// Optional feature macro: DMEM_MISALIGN_CHK_EN -- misaligned halfword/word
// requests complete immediately with err=1 instead of being aligned down.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int ADDR_W = 10
) (
  input  logic  clk,
  input  logic  rst,
  dmem_if.slave bus
`ifdef DMEM_MISALIGN_CHK_EN
  ,
  output logic  err
`endif
);

  state_e            r_state;
  logic [1:0]        r_off;
  logic [2:0]        r_type;
  logic              r_store;
  logic [DATA_W-1:0] r_dout;
  logic              r_ready;
  logic              r_mem_ce;
  logic              r_mem_we;
  logic [BE_W-1:0]   r_mem_be;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [DATA_W-1:0] r_mem_wdata;
  logic [DATA_W-1:0] w_load_data;
  logic              w_misalign;
  // Address bits above the SRAM range are ignored, so accesses wrap.
  logic              w_unused_addr_hi;

  assign w_unused_addr_hi = ^bus.addr[31:ADDR_W+2];

`ifdef DMEM_MISALIGN_CHK_EN
  logic r_err;
  assign w_misalign = misaligned(bus.RW_type, bus.addr[1:0]);
  assign err        = r_err;
`else
  assign w_misalign = 1'b0;
`endif

  load_extend u_load_extend (
    .i_rdata   (bus.mem_rdata),
    .i_off     (r_off),
    .i_rw_type (r_type),
    .o_data    (w_load_data)
  );

  // NOTE: state and outputs use non-blocking assignments so every register
  // samples the values from before this edge, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_off       <= '0;
      r_type      <= '0;
      r_store     <= 1'b0;
      r_dout      <= '0;
      r_ready     <= 1'b0;
      r_mem_ce    <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_be    <= '0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
`ifdef DMEM_MISALIGN_CHK_EN
      r_err       <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.W_en || bus.R_en) begin
            r_off       <= bus.addr[1:0];
            r_type      <= bus.RW_type;
            r_store     <= bus.W_en;
            r_mem_addr  <= bus.addr[ADDR_W+1:2];
            r_mem_wdata <= store_wdata(bus.RW_type, bus.din);
            if (w_misalign) begin
              // Rejected request: skip the SRAM and report at once.
              r_state <= S_DONE;
              r_ready <= 1'b1;
              r_dout  <= '0;
`ifdef DMEM_MISALIGN_CHK_EN
              r_err   <= 1'b1;
`endif
            end else begin
              // SRAM strobes are set here so they are high for all of ACCESS.
              r_state  <= S_ACCESS;
              r_mem_ce <= 1'b1;
              r_mem_we <= bus.W_en;
              r_mem_be <= bus.W_en ? store_be(bus.RW_type, bus.addr[1:0]) : '1;
            end
          end
        end
        S_ACCESS: begin
          r_mem_ce <= 1'b0;
          r_mem_we <= 1'b0;
          r_mem_be <= '0;
          if (r_store) begin
            r_state <= S_DONE;
            r_ready <= 1'b1;
          end else begin
            r_state <= S_WAIT;
          end
        end
        S_WAIT: begin
          r_dout  <= w_load_data;
          r_state <= S_DONE;
          r_ready <= 1'b1;
        end
        S_DONE: begin
          r_ready <= 1'b0;
`ifdef DMEM_MISALIGN_CHK_EN
          r_err   <= 1'b0;
`endif
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.dout      = r_dout;
  assign bus.ready     = r_ready;
  assign bus.mem_ce    = r_mem_ce;
  assign bus.mem_we    = r_mem_we;
  assign bus.mem_be    = r_mem_be;
  assign bus.mem_addr  = r_mem_addr;
  assign bus.mem_wdata = r_mem_wdata;

endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder -- self-checking bench for dmem_responder with a
// behavioural SRAM and a queue of expected load results.
module tb_dmem_responder;
  import dmem_pkg::*;

  localparam int ADDR_W = 10;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  dmem_if #(.ADDR_W(ADDR_W)) bus ();

`ifdef DMEM_MISALIGN_CHK_EN
  logic err;
`endif

  dmem_responder #(.ADDR_W(ADDR_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
`ifdef DMEM_MISALIGN_CHK_EN
    ,
    .err (err)
`endif
  );

  // Behavioural SRAM: byte-enabled write, read data one cycle later.
  logic [31:0] sram [0:(1<<ADDR_W)-1];
  always @(posedge clk) begin
    if (bus.mem_ce) begin
      if (bus.mem_we)
        for (int i = 0; i < 4; i++)
          if (bus.mem_be[i]) sram[bus.mem_addr][8*i +: 8] <= bus.mem_wdata[8*i +: 8];
      bus.mem_rdata <= sram[bus.mem_addr];
    end
  end

  int errors = 0;
  int checks = 0;
  logic [31:0] exp_q[$];
  logic [31:0] last_dout = '0;

  int              obs_ce_cnt;
  logic            obs_we;
  logic [3:0]      obs_be;
  logic [ADDR_W-1:0] obs_maddr;
  logic [31:0]     obs_wdata;

  // One request: drive at a negedge, drop it after capture, wait for ready.
  task automatic run_op(input logic r, input logic w, input logic [2:0] t,
                        input logic [31:0] a, input logic [31:0] d,
                        input int exp_lat, input logic exp_err, input string name);
    int cyc;
    bit done;
    logic [31:0] exp;
    @(negedge clk);
    bus.R_en = r; bus.W_en = w; bus.RW_type = t; bus.addr = a; bus.din = d;
    cyc = 0; done = 0; obs_ce_cnt = 0; obs_we = 0; obs_be = '0; obs_maddr = '0; obs_wdata = '0;
    while (!done && cyc < 12) begin
      @(posedge clk); @(negedge clk);
      cyc++;
      if (cyc == 1) begin
        bus.R_en = 0; bus.W_en = 0; bus.din = '0; bus.addr = 32'hFFFF_FFFF;
      end
      if (bus.mem_ce) begin
        obs_ce_cnt++;
        obs_we = bus.mem_we; obs_be = bus.mem_be; obs_maddr = bus.mem_addr; obs_wdata = bus.mem_wdata;
      end
      if (bus.ready) done = 1;
    end
    checks++;
    if (!done || cyc != exp_lat) begin
      errors++;
      $display("FAIL %s latency: got %0d cycles (done=%0b), expected %0d", name, cyc, done, exp_lat);
    end
    if (w && !exp_err) exp = last_dout;
    else if (exp_q.size() > 0) exp = exp_q.pop_front();
    else exp = 32'hBAD0_BAD0;
    checks++;
    if (bus.dout !== exp) begin
      errors++;
      $display("FAIL %s dout: got %08h, expected %08h", name, bus.dout, exp);
    end
    last_dout = exp;
`ifdef DMEM_MISALIGN_CHK_EN
    checks++;
    if (err !== exp_err) begin
      errors++;
      $display("FAIL %s err: got %0b, expected %0b", name, err, exp_err);
    end
`endif
    @(negedge clk);
    checks++;
    if (bus.ready !== 1'b0) begin
      errors++;
      $display("FAIL %s ready pulse: got %0b one cycle later, expected 0", name, bus.ready);
    end
  endtask

  task automatic test_reset();
    bus.R_en = 0; bus.W_en = 0; bus.addr = '0; bus.RW_type = RW_W; bus.din = '0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({bus.dout, bus.ready} !== 33'h0) begin
      errors++; $display("FAIL reset dout/ready: got %08h/%0b, expected 0/0", bus.dout, bus.ready);
    end
    checks++;
    if ({bus.mem_ce, bus.mem_we, bus.mem_be} !== 6'h0) begin
      errors++; $display("FAIL reset ce/we/be: got %0b/%0b/%04b, expected 0", bus.mem_ce, bus.mem_we, bus.mem_be);
    end
    checks++;
    if ({bus.mem_addr, bus.mem_wdata} !== '0) begin
      errors++; $display("FAIL reset mem_addr/wdata: got %0h/%08h, expected 0", bus.mem_addr, bus.mem_wdata);
    end
`ifdef DMEM_MISALIGN_CHK_EN
    checks++;
    if (err !== 1'b0) begin
      errors++; $display("FAIL reset err: got %0b, expected 0", err);
    end
`endif
    rst = 1'b0;
    last_dout = '0;
  endtask

  task automatic check_store(input string name, input logic [3:0] be, input logic [ADDR_W-1:0] ma,
                             input logic [31:0] wmask, input logic [31:0] wd);
    checks++;
    if (obs_ce_cnt != 1 || obs_we !== 1'b1 || obs_be !== be || obs_maddr !== ma || (obs_wdata & wmask) !== wd) begin
      errors++;
      $display("FAIL %s sram: ce_cycles=%0d we=%0b be=%04b addr=%0h wdata=%08h, expected 1/1/%04b/%0h/%08h (mask %08h)",
               name, obs_ce_cnt, obs_we, obs_be, obs_maddr, obs_wdata, be, ma, wd, wmask);
    end
  endtask

  task automatic test_word();
    run_op(0, 1, RW_W, 32'h10, 32'hDEADBEEF, 2, 0, "sw_10");
    check_store("sw_10", 4'b1111, 4, 32'hFFFF_FFFF, 32'hDEADBEEF);
    exp_q.push_back(32'hDEADBEEF);
    run_op(1, 0, RW_W, 32'h10, 0, 3, 0, "lw_10");
  endtask

  task automatic test_misalign();
`ifdef DMEM_MISALIGN_CHK_EN
    exp_q.push_back(32'h0);
    run_op(1, 0, RW_W, 32'h11, 0, 1, 1, "lw_11_err");
    checks++;
    if (obs_ce_cnt != 0) begin
      errors++; $display("FAIL lw_11_err mem_ce: high %0d cycles, expected 0", obs_ce_cnt);
    end
`else
    exp_q.push_back(32'hDEADBEEF);
    run_op(1, 0, RW_W, 32'h11, 0, 3, 0, "lw_11_align");
    checks++;
    if (obs_maddr !== 4) begin
      errors++; $display("FAIL lw_11_align mem_addr: got %0h, expected 4", obs_maddr);
    end
`endif
  endtask

  task automatic test_byte();
    run_op(0, 1, RW_B, 32'h13, 32'h000000A5, 2, 0, "sb_13");
    check_store("sb_13", 4'b1000, 4, 32'hFF00_0000, 32'hA500_0000);
    exp_q.push_back(32'hFFFFFFA5);
    run_op(1, 0, RW_B, 32'h13, 0, 3, 0, "lb_13");
    exp_q.push_back(32'h000000A5);
    run_op(1, 0, RW_BU, 32'h13, 0, 3, 0, "lbu_13");
  endtask

  task automatic test_half();
    run_op(0, 1, RW_H, 32'h22, 32'h00008001, 2, 0, "sh_22");
    check_store("sh_22", 4'b1100, 8, 32'hFFFF_0000, 32'h8001_0000);
    exp_q.push_back(32'hFFFF8001);
    run_op(1, 0, RW_H, 32'h22, 0, 3, 0, "lh_22");
    exp_q.push_back(32'h00008001);
    run_op(1, 0, RW_HU, 32'h22, 0, 3, 0, "lhu_22");
  endtask

  task automatic test_both_enables();
    run_op(1, 1, RW_W, 32'h30, 32'hCAFEF00D, 2, 0, "rw_both");
    check_store("rw_both", 4'b1111, 12, 32'hFFFF_FFFF, 32'hCAFEF00D);
    exp_q.push_back(32'hCAFEF00D);
    run_op(1, 0, RW_W, 32'h30, 0, 3, 0, "lw_30");
  endtask

  task automatic test_reset_abort();
    int rdy_seen;
    @(negedge clk);
    bus.W_en = 1; bus.R_en = 0; bus.RW_type = RW_W; bus.addr = 32'h30; bus.din = 32'h11111111;
    @(posedge clk); @(negedge clk);
    bus.W_en = 0;
    #1 rst = 1'b1;
    #1;
    checks++;
    if ({bus.mem_ce, bus.mem_we, bus.mem_be, bus.ready} !== 7'h0 || bus.dout !== 32'h0 ||
        bus.mem_addr !== '0 || bus.mem_wdata !== 32'h0) begin
      errors++;
      $display("FAIL abort outputs: ce=%0b we=%0b be=%04b rdy=%0b dout=%08h addr=%0h wdata=%08h, expected all 0",
               bus.mem_ce, bus.mem_we, bus.mem_be, bus.ready, bus.dout, bus.mem_addr, bus.mem_wdata);
    end
    @(negedge clk);
    rst = 1'b0;
    last_dout = '0;
    rdy_seen = 0;
    repeat (4) begin
      @(negedge clk);
      if (bus.ready) rdy_seen++;
    end
    checks++;
    if (rdy_seen != 0) begin
      errors++; $display("FAIL abort ready: pulsed %0d times, expected 0", rdy_seen);
    end
    exp_q.push_back(32'hCAFEF00D);
    run_op(1, 0, RW_W, 32'h30, 0, 3, 0, "lw_30_after_abort");
  endtask

  task automatic test_wrap();
    run_op(0, 1, RW_W, 32'h0000_1010, 32'h12345678, 2, 0, "sw_wrap");
    check_store("sw_wrap", 4'b1111, 4, 32'hFFFF_FFFF, 32'h12345678);
    exp_q.push_back(32'h12345678);
    run_op(1, 0, RW_W, 32'h10, 0, 3, 0, "lw_wrap");
  endtask

  task automatic test_back_to_back();
    logic [31:0] a, d;
    int o;
    logic [15:0] h;
    for (int i = 0; i < 4; i++) begin
      a = 32'($urandom_range(64, 255)) & 32'hFFFF_FFFC;
      d = $urandom;
      o = $urandom_range(0, 3);
      run_op(0, 1, RW_W, a, d, 2, 0, "rand_sw");
      exp_q.push_back({24'h0, d[8*o +: 8]});
      run_op(1, 0, RW_BU, a + 32'(o), 0, 3, 0, "rand_lbu");
      h = d[16*(o/2) +: 16];
      exp_q.push_back({{16{h[15]}}, h});
      run_op(1, 0, RW_H, a + 32'(o & 2), 0, 3, 0, "rand_lh");
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_word();
    test_misalign();
    test_byte();
    test_half();
    test_both_enables();
    test_reset_abort();
    test_wrap();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
